hazard_unit: RTL
================

// Module: hazard_unit
// PURPOSE
//  Stall/forward control for the 5-stage MIPS pipeline, directly downstream of the D-stage decoder.
//  Consumes decoder outputs: D_TuseRs, D_TuseRt, E_Tnew (sent as D_Tnew), dest reg, regWrite.
//  Pipelines destination/Tnew bookkeeping through E, M and W internally.
//  Emits: stall (freeze PC + F/D, bubble E), forwarding mux selects for D/E/M, saturating stall counter.
// PARAMETERS
//  CNT_W  32  width of stall performance counter
// PORTS
//  clk          in   1      clock; all state updates on posedge
//  reset        in   1      synchronous, active-high
//  D_rs         in   5      rs field of instr in D
//  D_rt         in   5      rt field of instr in D
//  D_A3         in   5      dest reg of instr in D (post regDst mux)
//  D_regWrite   in   1      instr in D writes GRF
//  D_TuseRs     in   2      decoder Tuse for rs (3 = unused)
//  D_TuseRt     in   2      decoder Tuse for rt (3 = unused)
//  D_Tnew       in   2      decoder E-stage Tnew (0 none, 1 ALU, 2 load/jal)
//  stall        out  1      1 = hold PC and F/D reg, bubble into D/E reg
//  D_fwdRs      out  2      D rs select: 00 GRF, 01 M result, 10 W result
//  D_fwdRt      out  2      D rt select, same encoding
//  E_fwdRs      out  2      ALU operand A select, same encoding
//  E_fwdRt      out  2      ALU operand B / store data select, same encoding
//  M_fwdRt      out  1      DM write-data select: 0 pipe reg, 1 W result
//  stall_count  out  CNT_W  cycles with stall=1 since reset, saturates
// BEHAVIOUR
//  State regs: E_{rs,rt,A3,Tnew}, M_{rt,A3,Tnew}, W_A3. Reset (sync): all zero, stall_count=0.
//  Effective A3 = regWrite ? A3 : 0. Reg 0 is never a hazard or forward source.
//  Posedge, reset=0:
//   - E <= stall ? bubble (all fields 0) : {D_rs, D_rt, eff D_A3, D_Tnew}.
//   - M <= {E_rt, E_A3, sat_dec(E_Tnew)}.
//   - W_A3 <= M_A3.
//   - sat_dec(x) = (x == 0) ? 0 : x - 1.
//  Stall, combinational from current D inputs and E/M regs:
//   - stall = hit(D_rs, D_TuseRs) | hit(D_rt, D_TuseRt).
//   - hit(r,T) = r != 0 & ((r == E_A3 & T < E_Tnew) | (r == M_A3 & T < M_Tnew)).
//   - Tuse = 3 never stalls (max Tnew is 2).
//  Forward selects, combinational:
//   - Source M is valid only when M_Tnew == 0. M has priority over W.
//   - D_fwd*: compare D_rs/D_rt. E_fwd*: compare E_rs/E_rt. M_fwdRt: M_rt == W_A3.
//   - All require r != 0 and r == source A3.
//  Outputs after reset: stall=0, all selects 0 (state zero, reg 0 excluded).
//  Simultaneous events:
//   - stall with hit on both E and M: a single stall cycle per clock; repeats until clear.
//   - reset during stall: reset wins and clears all state; stall drops the cycle after.
//  stall_count increments when stall=1 and it is below 2^CNT_W-1; then holds.
//  Latency: stall and selects are same-cycle combinational; tracking state advances 1 stage/clk.
// TESTING
//  - Load-use: lw $1 (Tnew 2) then add rs=$1 (Tuse 1).
//    -> stall=1 for exactly 1 cycle; add then in E with E_fwdRs=10; stall_count=1.
//  - Branch after load: lw $2 then beq rs=$2 (Tuse 0).
//    -> stall 2 cycles; 3rd cycle stall=0, D_fwdRs=10.
//  - Branch after ALU: add $3 then beq rt=$3.
//    -> stall 1 cycle, then D_fwdRt=01 (from M).
//  - Zero reg: ori $0 then add rs=$0, rt=$0.
//    -> no stall; all selects 00 in every cycle.
//  - Priority / store data: add $4; add $4; sw rt=$4.
//    -> E_fwdRt=01 (newer M wins over W); following cycle M_fwdRt=1.
//  - Reset mid-stall: assert reset while stall=1.
//    -> next cycle all state zero, stall=0, stall_count=0.

Source files
------------

// File: rtl/hazard_unit.sv
// Hazard unit for the 5-stage MIPS pipeline.
// Tracks destination register and remaining Tnew for the instructions in E, M and W.
// From these it produces the same-cycle stall and forwarding-mux selects.
// It also keeps a saturating count of stalled cycles.
module hazard_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       D_rs,
    input  logic [4:0]       D_rt,
    input  logic [4:0]       D_A3,
    input  logic             D_regWrite,
    input  logic [1:0]       D_TuseRs,
    input  logic [1:0]       D_TuseRt,
    input  logic [1:0]       D_Tnew,
    output logic             stall,
    output logic [1:0]       D_fwdRs,
    output logic [1:0]       D_fwdRt,
    output logic [1:0]       E_fwdRs,
    output logic [1:0]       E_fwdRt,
    output logic             M_fwdRt,
    output logic [CNT_W-1:0] stall_count
);

    // Forward-select encoding shared by all 2-bit mux selects
    localparam logic [1:0] SEL_GRF = 2'b00;
    localparam logic [1:0] SEL_M   = 2'b01;
    localparam logic [1:0] SEL_W   = 2'b10;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Per-stage bookkeeping; a bubble is all-zero, and A3 is already gated by regWrite
    logic [4:0] eRs, eRt, eA3;
    logic [1:0] eTnew;
    logic [4:0] mRt, mA3;
    logic [1:0] mTnew;
    logic [4:0] wA3;

    logic [4:0] dA3Eff;

    // Cycles until a result is produced, one stage later
    function automatic logic [1:0] satDec(input logic [1:0] x);
        return (x == 2'd0) ? 2'd0 : x - 2'd1;
    endfunction

    // A register read that cannot be satisfied in time by any forwarding path
    function automatic logic hit(
        input logic [4:0] r,
        input logic [1:0] tuse,
        input logic [4:0] a3E,
        input logic [1:0] tnewE,
        input logic [4:0] a3M,
        input logic [1:0] tnewM
    );
        return (r != 5'd0) &&
               (((r == a3E) && (tuse < tnewE)) || ((r == a3M) && (tuse < tnewM)));
    endfunction

    // M holds a usable result only once its Tnew has run out; M is newer, so it beats W
    function automatic logic [1:0] fwdSel(
        input logic [4:0] r,
        input logic [4:0] a3M,
        input logic [1:0] tnewM,
        input logic [4:0] a3W
    );
        if ((r != 5'd0) && (r == a3M) && (tnewM == 2'd0))
            return SEL_M;
        else if ((r != 5'd0) && (r == a3W))
            return SEL_W;
        else
            return SEL_GRF;
    endfunction

    assign dA3Eff = D_regWrite ? D_A3 : 5'd0;

    // Stall and forward selects from the D inputs and the current stage state
    always_comb begin
        // NOTE: every output gets a default first so no path through the block can infer a latch.
        stall   = 1'b0;
        D_fwdRs = SEL_GRF;
        D_fwdRt = SEL_GRF;
        E_fwdRs = SEL_GRF;
        E_fwdRt = SEL_GRF;
        M_fwdRt = 1'b0;

        stall = hit(D_rs, D_TuseRs, eA3, eTnew, mA3, mTnew) |
                hit(D_rt, D_TuseRt, eA3, eTnew, mA3, mTnew);

        D_fwdRs = fwdSel(D_rs, mA3, mTnew, wA3);
        D_fwdRt = fwdSel(D_rt, mA3, mTnew, wA3);
        E_fwdRs = fwdSel(eRs, mA3, mTnew, wA3);
        E_fwdRt = fwdSel(eRt, mA3, mTnew, wA3);
        M_fwdRt = (mRt != 5'd0) && (mRt == wA3);
    end

    // Advance the bookkeeping one stage per clock and count stalled cycles
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so each stage loads the pre-edge value of the stage before it.
        if (reset) begin
            eRs         <= '0;
            eRt         <= '0;
            eA3         <= '0;
            eTnew       <= '0;
            mRt         <= '0;
            mA3         <= '0;
            mTnew       <= '0;
            wA3         <= '0;
            stall_count <= '0;
        end else begin
            if (stall) begin
                eRs   <= '0;
                eRt   <= '0;
                eA3   <= '0;
                eTnew <= '0;
            end else begin
                eRs   <= D_rs;
                eRt   <= D_rt;
                eA3   <= dA3Eff;
                eTnew <= D_Tnew;
            end
            mRt   <= eRt;
            mA3   <= eA3;
            mTnew <= satDec(eTnew);
            wA3   <= mA3;
            if (stall && (stall_count != CNT_MAX))
                stall_count <= stall_count + CNT_ONE;
        end
    end

endmodule
